// File: rtl/jtcop_snd_pkg.sv
// rtl/jtcop_snd_pkg.sv - shared state encoding, default offsets and requester ids for the sound ROM arbiter
package jtcop_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_GAP      = 2'd2,
    ST_PREFETCH = 2'd3
  } state_t;

  localparam logic [20:0] CPU_OFFSET_DEF = 21'h0;
  localparam logic [20:0] PCM_OFFSET_DEF = 21'h10000;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_PCM = 1'b1;

endpackage

// File: rtl/jtcop_snd_wcache.sv
// rtl/jtcop_snd_wcache.sv - one-word (16-bit) read cache with tag compare, byte select and fill port
module jtcop_snd_wcache #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          fill_en,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_word,
  output logic          hit,
  output logic [7:0]    data,
  output logic [AW-2:0] tag,
  output logic [15:0]   word,
  output logic          valid
);

  logic [15:0]   word_q, word_d;
  logic [AW-2:0] tag_q, tag_d;
  logic          valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_en) begin
      word_d  = fill_word;
      tag_d   = fill_tag;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= 16'h0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign hit   = valid_q && (tag_q == addr[AW-1:1]);
  assign data  = addr[0] ? word_q[15:8] : word_q[7:0];
  assign tag   = tag_q;
  assign word  = word_q;
  assign valid = valid_q;

endmodule

// File: rtl/jtcop_snd_romarb.sv
// rtl/jtcop_snd_romarb.sv - shares one SDRAM read slot between sound CPU ROM and ADPCM ROM
// Optional ADPCM next-word prefetch buffer: JTCOP_SNDARB_PREFETCH_EN.
module jtcop_snd_romarb
  import jtcop_snd_pkg::*;
#(
  parameter int            CPU_AW     = 17,
  parameter int            PCM_AW     = 18,
  parameter int            SW         = 21,
  parameter logic [SW-1:0] CPU_OFFSET = CPU_OFFSET_DEF,
  parameter logic [SW-1:0] PCM_OFFSET = PCM_OFFSET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [PCM_AW-1:0] pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic              sdram_cs,
  output logic [SW-1:0]     sdram_addr,
  input  logic [15:0]       sdram_data,
  input  logic              sdram_ok
);

  localparam int TW = ((CPU_AW > PCM_AW) ? CPU_AW : PCM_AW) - 1;

  state_t        state_q, state_d;
  logic          serve_q, serve_d;
  logic          pcm_turn_q, pcm_turn_d;   // pcm wins the next contested grant
  logic [SW-1:0] sdram_addr_q, sdram_addr_d;
  logic [TW-1:0] cap_tag_q, cap_tag_d;

  logic              cpu_hit, pcm_hit, cpu_fill, pcm_fill, pcm_fill_en, pcm_valid;
  logic              cpu_miss, pcm_miss, pcm_need;
  logic [SW-1:0]     cpu_wa, pcm_wa;
  logic [PCM_AW-2:0] pcm_tag, pcm_fill_tag;
  logic [15:0]       pcm_fill_word;
  logic [CPU_AW-2:0] cpu_tag_unused;
  logic [15:0]       cpu_word_unused, pcm_word_unused;
  logic              cpu_valid_unused;

  assign cpu_miss = cpu_cs & ~cpu_hit;
  assign pcm_miss = pcm_cs & ~pcm_hit;
  assign cpu_wa   = SW'(cpu_addr[CPU_AW-1:1]) + CPU_OFFSET;
  assign pcm_wa   = SW'(pcm_addr[PCM_AW-1:1]) + PCM_OFFSET;
  assign cpu_ok   = cpu_cs & cpu_hit;
  assign pcm_ok   = pcm_cs & pcm_hit;

`ifdef JTCOP_SNDARB_PREFETCH_EN
  logic              nxt_hit, nxt_fill, nxt_valid, pcm_copy;
  logic [PCM_AW-2:0] nxt_tag, pf_tag;
  logic [15:0]       nxt_word;
  logic [7:0]        nxt_data_unused;

  assign pf_tag        = pcm_tag + 1'b1;
  assign pcm_need      = pcm_miss & ~nxt_hit;
  assign pcm_fill_en   = pcm_fill | pcm_copy;
  assign pcm_fill_word = pcm_copy ? nxt_word : sdram_data;
  assign pcm_fill_tag  = pcm_copy ? nxt_tag : cap_tag_q[PCM_AW-2:0];

  jtcop_snd_wcache #(.AW(PCM_AW)) u_nxt (
    .clk(clk), .rst_n(rst_n), .addr(pcm_addr), .fill_en(nxt_fill),
    .fill_tag(cap_tag_q[PCM_AW-2:0]), .fill_word(sdram_data), .hit(nxt_hit),
    .data(nxt_data_unused), .tag(nxt_tag), .word(nxt_word), .valid(nxt_valid)
  );
`else
  logic pcm_unused;

  assign pcm_need      = pcm_miss;
  assign pcm_fill_en   = pcm_fill;
  assign pcm_fill_word = sdram_data;
  assign pcm_fill_tag  = cap_tag_q[PCM_AW-2:0];
  assign pcm_unused    = ^{pcm_tag, pcm_valid};
`endif

  always_comb begin
    state_d      = state_q;
    serve_d      = serve_q;
    pcm_turn_d   = pcm_turn_q;
    sdram_addr_d = sdram_addr_q;
    cap_tag_d    = cap_tag_q;
    cpu_fill     = 1'b0;
    pcm_fill     = 1'b0;
`ifdef JTCOP_SNDARB_PREFETCH_EN
    pcm_copy     = 1'b0;
    nxt_fill     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef JTCOP_SNDARB_PREFETCH_EN
        pcm_copy = pcm_miss & nxt_hit;
`endif
        if (cpu_miss && !(pcm_need && pcm_turn_q)) begin
          state_d      = ST_FETCH;
          serve_d      = REQ_CPU;
          sdram_addr_d = cpu_wa;
          cap_tag_d    = TW'(cpu_addr[CPU_AW-1:1]);
        end else if (pcm_need) begin
          state_d      = ST_FETCH;
          serve_d      = REQ_PCM;
          sdram_addr_d = pcm_wa;
          cap_tag_d    = TW'(pcm_addr[PCM_AW-1:1]);
        end
`ifdef JTCOP_SNDARB_PREFETCH_EN
        else if (!pcm_miss && pcm_valid && !(nxt_valid && nxt_tag == pf_tag)) begin
          state_d      = ST_PREFETCH;
          sdram_addr_d = SW'(pf_tag) + PCM_OFFSET;
          cap_tag_d    = TW'(pf_tag);
        end
`endif
      end
      ST_FETCH: begin
        if (sdram_ok) begin
          if (serve_q == REQ_PCM) pcm_fill = 1'b1;
          else                    cpu_fill = 1'b1;
          pcm_turn_d = (serve_q == REQ_CPU);
          state_d    = ST_GAP;
        end
      end
`ifdef JTCOP_SNDARB_PREFETCH_EN
      ST_PREFETCH: begin
        if (sdram_ok) begin
          nxt_fill = 1'b1;
          state_d  = ST_GAP;
        end
      end
`endif
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      serve_q      <= REQ_CPU;
      pcm_turn_q   <= 1'b0;
      sdram_addr_q <= '0;
      cap_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      serve_q      <= serve_d;
      pcm_turn_q   <= pcm_turn_d;
      sdram_addr_q <= sdram_addr_d;
      cap_tag_q    <= cap_tag_d;
    end
  end

  assign sdram_cs   = (state_q == ST_FETCH) || (state_q == ST_PREFETCH);
  assign sdram_addr = sdram_addr_q;

  jtcop_snd_wcache #(.AW(CPU_AW)) u_cpu (
    .clk(clk), .rst_n(rst_n), .addr(cpu_addr), .fill_en(cpu_fill),
    .fill_tag(cap_tag_q[CPU_AW-2:0]), .fill_word(sdram_data), .hit(cpu_hit),
    .data(cpu_data), .tag(cpu_tag_unused), .word(cpu_word_unused), .valid(cpu_valid_unused)
  );

  jtcop_snd_wcache #(.AW(PCM_AW)) u_pcm (
    .clk(clk), .rst_n(rst_n), .addr(pcm_addr), .fill_en(pcm_fill_en),
    .fill_tag(pcm_fill_tag), .fill_word(pcm_fill_word), .hit(pcm_hit),
    .data(pcm_data), .tag(pcm_tag), .word(pcm_word_unused), .valid(pcm_valid)
  );

endmodule

// File: tb/tb_jtcop_snd_romarb.sv
// tb/tb_jtcop_snd_romarb.sv - self-checking bench for jtcop_snd_romarb with an SDRAM grant scoreboard
module tb_jtcop_snd_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cs;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        pcm_cs;
  logic [17:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic        sdram_cs;
  logic [20:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        sdram_ok;

  int checks   = 0;
  int failures = 0;
  logic [20:0] exp_q[$];

  jtcop_snd_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .sdram_cs(sdram_cs), .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_ok(sdram_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [20:0] a);
    if (a == 21'h04000) return 16'hA55A;
    return {a[7:0] ^ 8'hC3, a[7:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cpu_cs = 1'b0; pcm_cs = 1'b0;
    cpu_addr = '0; pcm_addr = '0; sdram_ok = 1'b0; sdram_data = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cs(output int waited);
    waited = 0;
    while (sdram_cs !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sdram_cs !== 1'b1) begin
      failures++;
      $display("FAIL wait_cs: sdram_cs=%b required 1 within 100 cycles", sdram_cs);
    end
  endtask

  task automatic respond(input int lat);
    logic [20:0] a, e;
    a = sdram_addr;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL grant_addr: got %h, no grant expected", a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL grant_addr: got %h required %h", a, e);
      end
    end
    repeat (lat - 1) @(negedge clk);
    checks++;
    if (sdram_cs !== 1'b1 || sdram_addr !== a) begin
      failures++;
      $display("FAIL fetch_hold: cs=%b addr=%h required cs=1 addr=%h", sdram_cs, sdram_addr, a);
    end
    sdram_data = word_of(a);
    sdram_ok   = 1'b1;
    @(negedge clk);
    sdram_ok   = 1'b0;
    sdram_data = 16'h0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sdram_cs !== 1'b0 || sdram_addr !== 21'h0) begin
      failures++;
      $display("FAIL reset_sdram: cs=%b addr=%h required 0/0", sdram_cs, sdram_addr);
    end
    cpu_cs = 1'b1; pcm_cs = 1'b1;
    #1;
    checks++;
    if (cpu_ok !== 1'b0 || pcm_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_ok: cpu_ok=%b pcm_ok=%b required 0/0", cpu_ok, pcm_ok);
    end
    checks++;
    if (cpu_data !== 8'h00 || pcm_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: cpu=%h pcm=%h required 00/00", cpu_data, pcm_data);
    end
  endtask

  task automatic test_cpu_miss();
    int w;
    do_reset();
    cpu_cs = 1'b1; cpu_addr = 17'h0_8001;
    exp_q.push_back(21'h04000);
    #1;
    checks++;
    if (cpu_ok !== 1'b0) begin
      failures++;
      $display("FAIL miss_ok_early: cpu_ok=%b required 0", cpu_ok);
    end
    wait_cs(w);
    respond(4);
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== 8'hA5) begin
      failures++;
      $display("FAIL miss_fill: cpu_ok=%b data=%h required 1/a5", cpu_ok, cpu_data);
    end
  endtask

  task automatic test_cpu_hit();
    logic seen;
    cpu_addr = 17'h0_8000;
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== 8'h5A) begin
      failures++;
      $display("FAIL hit_same_cycle: cpu_ok=%b data=%h required 1/5a", cpu_ok, cpu_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sdram_cs !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL hit_no_fetch: sdram_cs seen=%b required 0", seen);
    end
  endtask

  task automatic test_arbitration();
    int w;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(21'h00800 + 21'(2 * k));
      exp_q.push_back(21'h10008 + 21'(2 * k));
    end
    cpu_cs = 1'b1; cpu_addr = 17'h01000;
    pcm_cs = 1'b1; pcm_addr = 18'h00010;
    for (int g = 0; g < 8; g++) begin
      wait_cs(w);
      if (g > 0) begin
        checks++;
        if (w != 2) begin
          failures++;
          $display("FAIL gap_cycles: grant %0d idle cycles=%0d required 2", g, w);
        end
      end
      respond(2 + g % 3);
      if (g % 2 == 0) begin
        if (g < 6) cpu_addr = 17'h01000 + 17'(4 * (g / 2 + 1));
      end else if (g < 7) begin
        pcm_addr = 18'h00010 + 18'(4 * ((g + 1) / 2));
      end
    end
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || pcm_ok !== 1'b1 || cpu_data !== 8'h06 || pcm_data !== 8'h0E) begin
      failures++;
      $display("FAIL arb_final: cpu_ok=%b pcm_ok=%b cpu=%h pcm=%h required 1/1/06/0e",
               cpu_ok, pcm_ok, cpu_data, pcm_data);
    end
  endtask

  task automatic test_addr_change();
    int w;
    logic [15:0] old_w;
    old_w = word_of(21'h00080);
    do_reset();
    cpu_cs = 1'b1; cpu_addr = 17'h00100;
    exp_q.push_back(21'h00080);
    exp_q.push_back(21'h00100);
    wait_cs(w);
    cpu_addr = 17'h00200;
    respond(3);
    #1;
    checks++;
    if (cpu_ok !== 1'b0) begin
      failures++;
      $display("FAIL stale_fill_ok: cpu_ok=%b required 0", cpu_ok);
    end
    cpu_addr = 17'h00101;
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== old_w[15:8]) begin
      failures++;
      $display("FAIL stale_fill_tag: cpu_ok=%b data=%h required 1/%h", cpu_ok, cpu_data, old_w[15:8]);
    end
    cpu_addr = 17'h00200;
    wait_cs(w);
    checks++;
    if (cpu_ok !== 1'b0) begin
      failures++;
      $display("FAIL refetch_ok_early: cpu_ok=%b required 0", cpu_ok);
    end
    respond(3);
    cpu_addr = 17'h00201;
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== 8'hC3) begin
      failures++;
      $display("FAIL refetch_fill: cpu_ok=%b data=%h required 1/c3", cpu_ok, cpu_data);
    end
  endtask

  task automatic test_reset_midfetch();
    int w;
    do_reset();
    cpu_cs = 1'b1; cpu_addr = 17'h00300;
    wait_cs(w);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sdram_cs !== 1'b0 || sdram_addr !== 21'h0 || cpu_ok !== 1'b0 || pcm_ok !== 1'b0 || cpu_data !== 8'h00) begin
      failures++;
      $display("FAIL midfetch_reset: cs=%b addr=%h cpu_ok=%b pcm_ok=%b data=%h required 0/0/0/0/00",
               sdram_cs, sdram_addr, cpu_ok, pcm_ok, cpu_data);
    end
    cpu_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sdram_data = 16'hBEEF; sdram_ok = 1'b1;
    @(negedge clk);
    sdram_ok = 1'b0; sdram_data = 16'h0;
    cpu_cs = 1'b1;
    #1;
    checks++;
    if (cpu_ok !== 1'b0 || sdram_cs !== 1'b0) begin
      failures++;
      $display("FAIL late_ok_ignored: cpu_ok=%b cs=%b required 0/0", cpu_ok, sdram_cs);
    end
    exp_q.push_back(21'h00180);
    wait_cs(w);
    respond(2);
    #1;
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== 8'h80) begin
      failures++;
      $display("FAIL post_reset_fill: cpu_ok=%b data=%h required 1/80", cpu_ok, cpu_data);
    end
  endtask

`ifdef JTCOP_SNDARB_PREFETCH_EN
  task automatic test_prefetch();
    int w;
    logic seen;
    do_reset();
    pcm_cs = 1'b1; pcm_addr = 18'h00020;
    exp_q.push_back(21'h10010);
    exp_q.push_back(21'h10011);
    wait_cs(w);
    respond(3);
    #1;
    checks++;
    if (pcm_ok !== 1'b1 || pcm_data !== 8'h10) begin
      failures++;
      $display("FAIL pf_first: pcm_ok=%b data=%h required 1/10", pcm_ok, pcm_data);
    end
    wait_cs(w);
    respond(3);
    pcm_addr = 18'h00021;
    #1;
    checks++;
    if (pcm_ok !== 1'b1 || pcm_data !== 8'hD3) begin
      failures++;
      $display("FAIL pf_hit_hi: pcm_ok=%b data=%h required 1/d3", pcm_ok, pcm_data);
    end
    pcm_addr = 18'h00022;
    seen = 1'b0;
    for (int i = 0; i < 10 && pcm_ok !== 1'b1; i++) begin
      @(negedge clk);
      if (sdram_cs === 1'b1 && pcm_ok !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (pcm_ok !== 1'b1 || pcm_data !== 8'h11 || seen !== 1'b0) begin
      failures++;
      $display("FAIL pf_copy: pcm_ok=%b data=%h sdram_seen=%b required 1/11/0", pcm_ok, pcm_data, seen);
    end
    exp_q.push_back(21'h10012);
    wait_cs(w);
    respond(3);
    pcm_addr = 18'h00023;
    #1;
    checks++;
    if (pcm_ok !== 1'b1 || pcm_data !== 8'hD2) begin
      failures++;
      $display("FAIL pf_last: pcm_ok=%b data=%h required 1/d2", pcm_ok, pcm_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_miss();
    test_cpu_hit();
    test_arbitration();
    test_addr_change();
    test_reset_midfetch();
`ifdef JTCOP_SNDARB_PREFETCH_EN
    test_prefetch();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL grants_left: %0d expected grants never issued, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
